// File: rtl/fpu_mant_divider.sv
// fpu_mant_divider
// ----------------
// Sequential unsigned restoring divider for floating-point mantissas. It is the
// divide-path counterpart of the shift-add mantissa multiplier and uses the same
// handshake: a one-cycle start pulse, then a level done. One quotient bit is
// produced per clock, for FRAC_WIDTH+3 iterations in total.
//
// The quotient carries guard and round bits, and the sticky bit reports a
// nonzero final remainder. Both feed the FPU rounding stage.
//
// Ports:
//   clock      system clock
//   reset      asynchronous, active-high reset
//   start      one-cycle pulse; latches the operands and starts (or restarts)
//              a division from any state
//   divIn1     dividend mantissa (FRAC_WIDTH+1 bits, hidden bit included)
//   divIn2     divisor mantissa  (FRAC_WIDTH+1 bits, hidden bit included)
//   quotient   floor(divIn1 * 2^(FRAC_WIDTH+2) / divIn2); valid while done=1
//   sticky     final remainder is nonzero; valid while done=1
//   divByZero  latched flag: divIn2 == 0
//   overflow   latched flag: divIn1 >= 2*divIn2, with divIn2 != 0
//   done       result valid; held high until the next start or reset
module fpu_mant_divider #(
  parameter int FRAC_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FRAC_WIDTH:0]   divIn1,
  input  logic [FRAC_WIDTH:0]   divIn2,
  output logic [FRAC_WIDTH+2:0] quotient,
  output logic                  sticky,
  output logic                  divByZero,
  output logic                  overflow,
  output logic                  done
);

  localparam int QW = FRAC_WIDTH + 3;        // quotient / remainder width
  localparam int CW = $clog2(QW + 1);        // counter covers 0..QW

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    COMP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [QW-1:0]         rem_q, rem_d;
  logic [FRAC_WIDTH:0]   dvs_q, dvs_d;
  logic [QW-1:0]         quot_q, quot_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  dbz_q, dbz_d;
  logic                  ovf_q, ovf_d;

  logic [QW-1:0]         dvs_ext;
  logic                  rem_ge;
  logic [QW-1:0]         rem_sub;
  logic                  force_ones;

  assign dvs_ext = {2'b00, dvs_q};
  assign rem_ge  = (rem_q >= dvs_ext);
  assign rem_sub = rem_q - dvs_ext;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    if (start) begin
      // A start pulse always wins: it aborts a running division and also
      // leaves DONE directly, so no reset is needed between operations.
      rem_d   = {2'b00, divIn1};
      dvs_d   = divIn2;
      quot_d  = '0;
      cnt_d   = '0;
      dbz_d   = (divIn2 == '0);
      // Overflow means the quotient would need a bit above the top position,
      // which happens when the dividend is at least twice the divisor.
      ovf_d   = (divIn2 != '0) && ({1'b0, divIn1} >= {divIn2, 1'b0});
      state_d = COMP;
    end else begin
      case (state_q)
        WAIT: ;
        COMP: begin
          quot_d = {quot_q[QW-2:0], rem_ge};
          rem_d  = rem_ge ? (rem_sub << 1) : (rem_q << 1);
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(QW - 1)) begin
            state_d = DONE;
          end
        end
        DONE: ;
        default: state_d = WAIT;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= WAIT;
      rem_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  // The iterations still run for exceptional operands, so the latency stays
  // fixed. The garbage they produce is masked here with a saturated quotient.
  assign done       = (state_q == DONE);
  assign force_ones = done && (dbz_q || ovf_q);
  assign quotient   = force_ones ? '1 : quot_q;
  assign sticky     = done && !force_ones && (rem_q != '0);
  assign divByZero  = dbz_q;
  assign overflow   = ovf_q;

endmodule
